// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I integer-computational decode stage:
// opcode/funct7 constants, ALU operation encodings and the decoded bundle.
package alu_pkg;

  localparam int XLEN_C = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation code is {sub/arith bit, funct3}.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd13
  } alu_op_e;

  // Decoded bundle handed to the execute stage.
  typedef struct packed {
    logic                illegal;
    logic                rd_we;
    logic                use_imm;
    logic [3:0]          alu_op;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN_C-1:0]   imm;
  } dec_t;

endpackage

// File: rtl/alu_dec_logic.sv
// Purely combinational RV32I decoder for OP, OP-IMM and LUI.
// Anything else is reported as illegal with all control fields zeroed,
// while the raw register fields still pass through.
module alu_dec_logic
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Decode the instruction word into the ALU control bundle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (otherwise a latch would be inferred).
    dec_o         = '0;
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.rd      = instr_i[11:7];
    dec_o.illegal = 1'b1;

    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          dec_o.illegal = 1'b0;
          dec_o.rd_we   = 1'b1;
          dec_o.alu_op  = {instr_i[30], funct3};
        end
      end

      OPC_OP_IMM: begin
        unique case (funct3)
          3'd1: begin
            if (funct7 == F7_BASE) begin
              dec_o.illegal = 1'b0;
              dec_o.alu_op  = ALU_SLL;
              dec_o.imm     = {27'b0, instr_i[24:20]};
            end
          end
          3'd5: begin
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
              dec_o.illegal = 1'b0;
              dec_o.alu_op  = {instr_i[30], funct3};
              dec_o.imm     = {27'b0, instr_i[24:20]};
            end
          end
          default: begin
            dec_o.illegal = 1'b0;
            dec_o.alu_op  = {1'b0, funct3};
            dec_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
          end
        endcase
        if (!dec_o.illegal) begin
          dec_o.rd_we   = 1'b1;
          dec_o.use_imm = 1'b1;
          dec_o.rs2     = 5'd0;
        end
      end

      OPC_LUI: begin
        dec_o.illegal = 1'b0;
        dec_o.rd_we   = 1'b1;
        dec_o.use_imm = 1'b1;
        dec_o.alu_op  = ALU_ADD;
        dec_o.rs1     = 5'd0;
        dec_o.imm     = {instr_i[31:12], 12'b0};
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Pipelined decode stage between fetch and execute with valid/ready on both
// sides and one cycle of latency.
// Build option ALU_DEC_SKID_EN: adds a second (skid) entry so in_ready comes
// straight from a register. Without it, a single output register is used and
// in_ready = !out_valid || out_ready.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            rd_we,
  output logic            illegal
);

  dec_t dec_w;
  dec_t out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic in_fire;

  alu_dec_logic u_dec (
    .instr_i (in_instr),
    .dec_o   (dec_w)
  );

  assign in_fire = in_valid & in_ready;

`ifdef ALU_DEC_SKID_EN
  dec_t skid_q, skid_d;
  logic skid_valid_q, skid_valid_d;

  // Ready is registered: accept whenever the skid slot is free.
  assign in_ready = !skid_valid_q;

  // Next-state for output and skid entries; flush wins over any handshake.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the drain of the skid entry matters.
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = in_fire;
      if (in_fire) out_d = dec_w;
    end else if (in_fire) begin
      // Output stalled: absorb the one entry already in flight.
      skid_valid_d = 1'b1;
      skid_d       = dec_w;
    end
  end

  // Skid entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  // Ready whenever the output slot is empty or being consumed this cycle.
  assign in_ready = !out_valid_q || out_ready;

  // Next-state for the single output entry; flush wins over any handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_valid_d = 1'b1;
      out_d       = dec_w;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset too, because the data outputs must
    // read zero after reset, not just out_valid.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates at the edge
      // see the pre-edge values.
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = out_q.alu_op;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign use_imm   = out_q.use_imm;
  assign rd_we     = out_q.rd_we;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage. Inputs change and outputs are
// sampled on the falling edge; the DUT captures on the rising edge.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        use_imm, rd_we, illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] instr_tab [8];
  logic [53:0] exp_tab   [8];
  logic [31:0] slli_bad_instr, ill03_instr;
  logic [53:0] slli_bad_exp, ill03_exp;

  logic [53:0] cur_vec;
  assign cur_vec = {illegal, rd_we, use_imm, alu_op, rs1, rs2, rd, imm};

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .use_imm   (use_imm),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  function automatic logic [53:0] mk(input logic ill, input logic we,
                                     input logic ui, input logic [3:0] op,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] rdx, input logic [31:0] im);
    return {ill, we, ui, op, r1, r2, rdx, im};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tests_run++;
    if (cur_vec !== 54'h0) begin
      tests_failed++; $display("FAIL reset_data: got %h expected 0", cur_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    @(negedge clk); drive(1'b1, instr_tab[0], 1'b1); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL add_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk); drive(1'b0, 32'h0, 1'b1);
    tests_run++;
    if ({out_valid, cur_vec} !== {1'b1, exp_tab[0]}) begin
      tests_failed++; $display("FAIL add: got %b/%h expected 1/%h", out_valid, cur_vec, exp_tab[0]);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL add_drained: got out_valid %b expected 0", out_valid);
    end
  endtask

  // Two consecutive accepts must produce two consecutive valid outputs.
  task automatic test_pair(input string name, input int a, input int b);
    @(negedge clk); drive(1'b1, instr_tab[a], 1'b1);
    @(negedge clk); drive(1'b1, instr_tab[b], 1'b1);
    tests_run++;
    if ({out_valid, cur_vec} !== {1'b1, exp_tab[a]}) begin
      tests_failed++; $display("FAIL %s_first: got %b/%h expected 1/%h", name, out_valid, cur_vec, exp_tab[a]);
    end
    @(negedge clk); drive(1'b0, 32'h0, 1'b1);
    tests_run++;
    if ({out_valid, cur_vec} !== {1'b1, exp_tab[b]}) begin
      tests_failed++; $display("FAIL %s_second: got %b/%h expected 1/%h", name, out_valid, cur_vec, exp_tab[b]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    test_pair("sub_srai", 1, 2);
  endtask

  task automatic test_imm();
    test_pair("addi_lui", 3, 4);
  endtask

  task automatic test_illegal();
    @(negedge clk); drive(1'b1, instr_tab[5], 1'b1);
    @(negedge clk); drive(1'b1, slli_bad_instr, 1'b1);
    tests_run++;
    if ({out_valid, cur_vec} !== {1'b1, exp_tab[5]}) begin
      tests_failed++; $display("FAIL ill_mul: got %b/%h expected 1/%h", out_valid, cur_vec, exp_tab[5]);
    end
    @(negedge clk); drive(1'b1, ill03_instr, 1'b1);
    tests_run++;
    if ({out_valid, cur_vec} !== {1'b1, slli_bad_exp}) begin
      tests_failed++; $display("FAIL ill_slli: got %b/%h expected 1/%h", out_valid, cur_vec, slli_bad_exp);
    end
    @(negedge clk); drive(1'b0, 32'h0, 1'b1);
    tests_run++;
    if ({out_valid, cur_vec} !== {1'b1, ill03_exp}) begin
      tests_failed++; $display("FAIL ill_opc03: got %b/%h expected 1/%h", out_valid, cur_vec, ill03_exp);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int          tx = 0, rx = 0, cyc = 0;
    logic        stalled = 1'b0;
    logic [53:0] held = '0;
    logic        ir_before;
    while (rx < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        tests_run++;
        if ({out_valid, cur_vec} !== {1'b1, held}) begin
          tests_failed++; $display("FAIL stream_stall_hold: got %b/%h expected 1/%h", out_valid, cur_vec, held);
        end
      end
      ir_before = in_ready;
      drive(tx < 8, (tx < 8) ? instr_tab[tx] : 32'h0, 1'($urandom_range(0, 1)));
      #1;
`ifdef ALU_DEC_SKID_EN
      tests_run++;
      if (in_ready !== ir_before) begin
        tests_failed++; $display("FAIL stream_ready_comb: got %b expected %b", in_ready, ir_before);
      end
`endif
      stalled = out_valid && !out_ready;
      held    = cur_vec;
      if (out_valid && out_ready) begin
        tests_run++;
        if (rx > 7 || cur_vec !== exp_tab[rx & 7]) begin
          tests_failed++; $display("FAIL stream_item%0d: got %h expected %h", rx, cur_vec, exp_tab[rx & 7]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    tests_run++;
    if (rx != 8) begin
      tests_failed++; $display("FAIL stream_count: got %0d expected 8 (timeout)", rx);
    end
    @(negedge clk); drive(1'b0, 32'h0, 1'b1);
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stream_no_dup: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); drive(1'b1, instr_tab[0], 1'b0);
    @(negedge clk); drive(1'b1, instr_tab[1], 1'b0);
    @(negedge clk); drive(1'b1, instr_tab[6], 1'b1); flush = 1'b1;
    @(negedge clk); drive(1'b0, 32'h0, 1'b1); flush = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_discard: got out_valid %b expected 0 (%h)", out_valid, cur_vec);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, instr_tab[7], 1'b0);
    @(negedge clk); drive(1'b1, instr_tab[6], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, cur_vec} !== 55'h0) begin
      tests_failed++; $display("FAIL reset_mid_async: got %b/%h expected 0/0", out_valid, cur_vec);
    end
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++; $display("FAIL reset_mid_release: got ready/valid %b%b expected 10", in_ready, out_valid);
    end
  endtask

  initial begin
    instr_tab[0] = 32'h002081B3; exp_tab[0] = mk(1'b0, 1'b1, 1'b0, 4'd0,  5'd1, 5'd2, 5'd3, 32'h0);
    instr_tab[1] = 32'h407302B3; exp_tab[1] = mk(1'b0, 1'b1, 1'b0, 4'd8,  5'd6, 5'd7, 5'd5, 32'h0);
    instr_tab[2] = 32'h40415093; exp_tab[2] = mk(1'b0, 1'b1, 1'b1, 4'd13, 5'd2, 5'd0, 5'd1, 32'h4);
    instr_tab[3] = 32'hFFF00093; exp_tab[3] = mk(1'b0, 1'b1, 1'b1, 4'd0,  5'd0, 5'd0, 5'd1, 32'hFFFFFFFF);
    instr_tab[4] = 32'h12345137; exp_tab[4] = mk(1'b0, 1'b1, 1'b1, 4'd0,  5'd0, 5'd3, 5'd2, 32'h12345000);
    instr_tab[5] = 32'h02208033; exp_tab[5] = mk(1'b1, 1'b0, 1'b0, 4'd0,  5'd1, 5'd2, 5'd0, 32'h0);
    instr_tab[6] = 32'h0062C233; exp_tab[6] = mk(1'b0, 1'b1, 1'b0, 4'd4,  5'd5, 5'd6, 5'd4, 32'h0);
    instr_tab[7] = 32'h009463B3; exp_tab[7] = mk(1'b0, 1'b1, 1'b0, 4'd6,  5'd8, 5'd9, 5'd7, 32'h0);
    slli_bad_instr = 32'h40209093; slli_bad_exp = mk(1'b1, 1'b0, 1'b0, 4'd0, 5'd1, 5'd2, 5'd1, 32'h0);
    ill03_instr    = 32'h00000003; ill03_exp    = mk(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);

    test_reset();
    test_add();
    test_back_to_back();
    test_imm();
    test_illegal();
    test_stream();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Pipelined decode stage that turns 32-bit RV32I integer-computational instructions into the 4-bit operation code, register indices and immediate consumed by the execute-stage ALU. It sits between fetch and execute, with a valid/ready handshake on both sides. Output is registered with one cycle of latency. Instructions outside OP, OP-IMM and LUI are flagged illegal, not dropped.

## Interface
Parameters:
- `XLEN`, 32: datapath/immediate width; only 32 is supported.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous; discards all held entries.
- `in_valid`  in  1  fetch presents `in_instr`.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  raw instruction word.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  execute consumes this cycle.
- `alu_op`  out  4  {sub/arith bit, funct3}.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `imm`  out  32  operand-B immediate.
- `use_imm`  out  1  ALU B operand = `imm`.
- `rd_we`  out  1  writeback enable.
- `illegal`  out  1  unsupported/malformed instruction.

## Operation
- `alu_op[2:0]` = funct3 (instr[14:12]) for OP/OP-IMM; `alu_op[3]` = instr[30] only for OP funct3 0/5 and OP-IMM funct3 5; otherwise 0.
- OP (0110011): funct7 0000000 with any funct3, or 0100000 with funct3 0/5. Any other funct7 (incl. 0000001 M-ext) is illegal. `use_imm`=0.
- OP-IMM (0010011): `imm` = sign-extended instr[31:20]. funct3 1 requires instr[31:25]=0. funct3 5 requires instr[31:25] ∈ {0000000, 0100000}. For funct3 1/5, `imm` = {27'b0, instr[24:20]}. `rs2`=0, `use_imm`=1.
- LUI (0110111): `imm` = {instr[31:12], 12'b0}; `rs1` forced 0; `alu_op`=0; `use_imm`=1.
- Legal entries: `rd_we`=1 (also when rd=0). Illegal entries: `illegal`=1, `rd_we`=0, `alu_op`=0, `imm`=0, `use_imm`=0. Register fields pass through raw.
- Handshake: transfer on valid&ready. `out_valid` holds and all outputs stay stable until `out_ready`. `in_ready` does not depend on `in_valid`.
- `flush`: next cycle `out_valid`=0, buffers empty; an input handshaked in the flush cycle is discarded.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, all data outputs 0.
- Latency: accept at edge N, `out_valid` at N+1; throughput one per cycle with `out_ready` held high.
- Accept and consume in the same cycle with one entry held: the new entry replaces it, with no bubble.
- Reset asserted mid-stream: all entries lost immediately (asynchronous); `in_ready` returns to 1 on the first edge after release.
- `flush` has priority over concurrent handshakes.

## Configuration
- `ALU_DEC_SKID_EN` defined: adds a 2-entry skid buffer. `in_ready` comes straight from a register (= skid slot empty). One extra entry is absorbed when `out_ready` drops. Full rate is kept.
- Not defined: single output register, with `in_ready` = !`out_valid` || `out_ready` (combinational path from `out_ready`).
- Both builds have identical decode results and 1-cycle latency.

## Structure
- Shared package `alu_pkg`: opcode constants (OP, OP_IMM, LUI), funct7 constants, ALU op encodings (ADD=0, SUB=8, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, SRA=13, OR=6, AND=7), and a packed `dec_t` struct for the decoded bundle.
- Sub-module `alu_dec_logic`: purely combinational `in_instr` → `dec_t`. The top holds handshake, skid and flush logic.

## Test plan
- ADD x3,x1,x2 (0x002081B3), out_ready=1 → next cycle alu_op=0, rs1=1, rs2=2, rd=3, use_imm=0, rd_we=1.
- SUB x5,x6,x7 (0x407302B3), then SRAI x1,x2,4 (0x40415093) back-to-back → alu_op=8, then alu_op=13, imm=4, use_imm=1; no bubble.
- ADDI x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF, alu_op=0. LUI x2,0x12345 (0x12345137) → imm=0x12345000, rs1=0.
- MUL (0x02208033), SLLI with instr[30]=1 (0x40209093), opcode 0x03 → illegal=1, rd_we=0 for each.
- Stream of 8 instructions with out_ready toggled randomly → all 8 emitted in order, none duplicated; outputs stable while stalled; with SKID_EN, in_ready never falls combinationally.
- Two entries held, flush pulsed while in_valid=1 → out_valid=0 next cycle; the input accepted during flush never appears. Reset mid-stream → out_valid=0 immediately.
